// File: rtl/bitwise_logic_unit_pkg.sv
// rtl/bitwise_logic_unit_pkg.sv - op codes and shared types for the bitwise logic unit
package bitwise_logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOT  = 3'd0;
    localparam op_t OP_AND  = 3'd1;
    localparam op_t OP_OR   = 3'd2;
    localparam op_t OP_XOR  = 3'd3;
    localparam op_t OP_NAND = 3'd4;
    localparam op_t OP_NOR  = 3'd5;
    localparam op_t OP_XNOR = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// rtl/bitwise_logic_unit_if.sv - operand/result handshake bundle for the bitwise logic unit
interface bitwise_logic_unit_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     result;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [CNT_W-1:0] op_count;

    // Operand source / result sink side
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ones, parity, op_count
    );

    // Logic unit side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, ones, parity, op_count
    );
endinterface

// File: rtl/bitwise_pipe_stage.sv
// rtl/bitwise_pipe_stage.sv - one valid/ready register slice
module bitwise_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot is free when empty or when its content leaves this cycle
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Refill/empty the slot; data only moves on an actual transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end
endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - two-stage pipelined 8-op bitwise unit with flags and counter
module bitwise_logic_unit
    import bitwise_logic_unit_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    bitwise_logic_unit_if.slave bus
);
    logic [N-1:0]     op_res;
    logic             s1_valid;
    logic [N-1:0]     s1_data;
    logic             s2_ready;
    logic             s1_zero;
    logic             s1_ones;
    logic             s1_parity;
    logic             s2_valid;
    logic [N+2:0]     s2_data;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Op mux feeding stage 1
    always_comb begin
        op_res = '0;
        case (bus.op)
            OP_NOT:  op_res = ~bus.a;
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            OP_XOR:  op_res = bus.a ^ bus.b;
            OP_NAND: op_res = ~(bus.a & bus.b);
            OP_NOR:  op_res = ~(bus.a | bus.b);
            OP_XNOR: op_res = ~(bus.a ^ bus.b);
            OP_PASS: op_res = bus.a;
            default: op_res = '0;
        endcase
    end

    bitwise_pipe_stage #(.W(N)) u_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_data_i   (op_res),
        .in_ready_o  (bus.in_ready),
        .out_valid_o (s1_valid),
        .out_data_o  (s1_data),
        .out_ready_i (s2_ready)
    );

    // Flags are derived from the registered S1 result so S2 carries them alongside it
    always_comb begin
        s1_zero   = (s1_data == '0);
        s1_ones   = &s1_data;
        s1_parity = ^s1_data;
    end

    bitwise_pipe_stage #(.W(N + 3)) u_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_data_i   ({s1_data, s1_zero, s1_ones, s1_parity}),
        .in_ready_o  (s2_ready),
        .out_valid_o (s2_valid),
        .out_data_o  (s2_data),
        .out_ready_i (bus.out_ready)
    );

    // An empty output stage presents the idle values of a zero result
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_valid ? s2_data[N+2:3] : '0;
    assign bus.zero      = s2_valid ? s2_data[2] : 1'b1;
    assign bus.ones      = s2_valid ? s2_data[1] : 1'b0;
    assign bus.parity    = s2_valid ? s2_data[0] : 1'b0;
    assign bus.op_count  = cnt_q;

    // Count output transfers, holding at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid && bus.out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Completion counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;
    localparam int N     = 32;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit_if #(.N(N), .CNT_W(CNT_W)) bus ();

    bitwise_logic_unit #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;   // {zero, ones, parity}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int exp_cnt;
    int got;
    int xfers;
    int idx;
    logic [31:0] bp_exp[5];
    logic saw_low;
    logic prev_hold;
    logic [31:0] prev_res;
    logic in_x;
    logic out_x;
    logic filled;

    initial begin
        vecs[0]  = '{3'd0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h0F0F_EDCB, 3'b001};
        vecs[1]  = '{3'd1, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 3'b001};
        vecs[2]  = '{3'd2, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 3'b000};
        vecs[3]  = '{3'd3, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 3'b001};
        vecs[4]  = '{3'd4, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF0F_FFCB, 3'b001};
        vecs[5]  = '{3'd5, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00, 3'b000};
        vecs[6]  = '{3'd6, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00FF_ED34, 3'b001};
        vecs[7]  = '{3'd7, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF0F0_1234, 3'b001};
        vecs[8]  = '{3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 3'b100};
        vecs[9]  = '{3'd5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b010};
        vecs[10] = '{3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 3'b001};

        // Reset state
        do_reset();
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_flags", {bus.zero, bus.ones, bus.parity}, 3'b100);
        check("rst_result", bus.result, 32'h0);
        check("rst_op_count", bus.op_count, 3'd0);

        // One beat per vector, latency and flags checked
        exp_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.op        = vecs[i].op;
            bus.a         = vecs[i].a;
            bus.b         = vecs[i].b;
            bus.out_ready = 1'b1;
            #1 check("vec_in_ready", bus.in_ready, 1'b1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("vec_lat1_idle", bus.out_valid, 1'b0);
            @(posedge clk); #1;
            check("vec_out_valid", bus.out_valid, 1'b1);
            check("vec_result", bus.result, vecs[i].res);
            check("vec_flags", {bus.zero, bus.ones, bus.parity}, vecs[i].flags);
            if (exp_cnt < 7) exp_cnt++;
            @(posedge clk); #1;
            check("vec_drained", bus.out_valid, 1'b0);
            check("vec_op_count", bus.op_count, exp_cnt[2:0]);
        end

        // Backpressure: 5 back-to-back beats, out_ready low in cycles 3..6
        do_reset();
        for (int k = 0; k < 5; k++) bp_exp[k] = 32'h1111_1111 * (k + 1);
        got = 0; idx = 0; saw_low = 1'b0; prev_hold = 1'b0; prev_res = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = (idx < 5);
            bus.op        = 3'd7;
            bus.a         = (idx < 5) ? bp_exp[idx] : 32'h0;
            bus.b         = 32'hA5A5_A5A5;
            #1;
            if (prev_hold) begin
                check("bp_hold_valid", bus.out_valid, 1'b1);
                check("bp_hold_result", bus.result, prev_res);
            end
            if (bus.in_valid && !bus.in_ready) saw_low = 1'b1;
            in_x  = bus.in_valid && bus.in_ready;
            out_x = bus.out_valid && bus.out_ready;
            if (out_x) begin
                check("bp_order", bus.result, bp_exp[got]);
                got++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res  = bus.result;
            @(posedge clk); #1;
            if (in_x) idx++;
        end
        bus.in_valid = 1'b0;
        check("bp_count_out", got, 5);
        check("bp_in_ready_dropped", saw_low, 1'b1);
        check("bp_op_count", bus.op_count, 3'd5);

        // Saturation: 10 transfers on a 3-bit counter
        do_reset();
        xfers = 0; idx = 0;
        for (int c = 0; c < 40 && xfers < 10; c++) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (idx < 10);
            bus.op        = 3'd0;
            bus.a         = 32'(idx);
            #1;
            check("sat_op_count", bus.op_count, (xfers < 7) ? 3'(xfers) : 3'd7);
            in_x  = bus.in_valid && bus.in_ready;
            out_x = bus.out_valid && bus.out_ready;
            if (out_x) xfers++;
            @(posedge clk); #1;
            if (in_x) idx++;
        end
        bus.in_valid = 1'b0;
        check("sat_xfers", xfers, 10);
        #1 check("sat_final", bus.op_count, 3'd7);

        // Reset while two beats are held by a stall
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd7;
        bus.a         = 32'hCAFE_0001;
        filled = 1'b0;
        for (int c = 0; c < 10 && !filled; c++) begin
            @(posedge clk); #1;
            if (!bus.in_ready) filled = 1'b1;
        end
        check("ms_filled", filled, 1'b1);
        bus.in_valid = 1'b0;
        #1 check("ms_held_valid", bus.out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("ms_async_out_valid", bus.out_valid, 1'b0);
        check("ms_async_in_ready", bus.in_ready, 1'b1);
        check("ms_async_result", bus.result, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("ms_no_stale", bus.out_valid, 1'b0);
        end
        check("ms_op_count", bus.op_count, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
